// File: rtl/balance_ledger_pkg.sv
// ledger_pkg: shared state/op encodings and BCD helpers for the balance ledger
package ledger_pkg;
    typedef enum logic [1:0] {IDLE, ENTRY, CALC, WB} state_t;
    typedef enum logic {OP_CHG, OP_TOP} op_t;
    localparam logic [11:0] BCD_MAX = 12'h999;
    function automatic logic bcd_ok(input logic [11:0] v);
        return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v[11:8] <= 4'd9;
    endfunction
endpackage

// File: rtl/balance_ledger_if.sv
// balance_ledger_if: charge request/ack/done handshake between billing and the ledger
interface balance_ledger_if;
    logic        chg_req;
    logic [11:0] chg_amt;
    logic        chg_ack;
    logic        chg_err;
    logic        chg_done;
    modport master (output chg_req, chg_amt, input chg_ack, chg_err, chg_done);
    modport slave (input chg_req, chg_amt, output chg_ack, chg_err, chg_done);
endinterface

// File: rtl/balance_ledger_alu.sv
// bcd_digit_alu: one-digit BCD add/sub with carry/borrow in and out
module bcd_digit_alu (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       sub,
    output logic [3:0] d,
    output logic       co
);
    logic [4:0] s;
    always_comb begin
        s = sub ? {1'b0, a} - {1'b0, b} - {4'b0, ci} : {1'b0, a} + {1'b0, b} + {4'b0, ci};
        co = sub ? s[4] : s > 5'd9;
        d = co ? (sub ? s[3:0] - 4'd6 : s[3:0] + 4'd6) : s[3:0];
    end
endmodule

// File: rtl/balance_ledger.sv
// balance_ledger: sign/BCD-magnitude balance with charge handshake and button top-up entry
module balance_ledger import ledger_pkg::*; #(
    parameter int          CLK_HZ    = 100_000_000,
    parameter int          TIMEOUT_S = 8,
    parameter logic [11:0] INIT_BAL  = 12'h196
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   on,
    input  logic                   sel_p,
    input  logic                   inc_p,
    input  logic                   ok_p,
    balance_ledger_if.slave        chg,
    output logic [11:0]            bal,
    output logic                   bal_neg,
    output logic [11:0]            entry,
    output logic [1:0]             entry_pos,
    output logic                   busy
);
    localparam int TW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    localparam int SW = $clog2(TIMEOUT_S + 1);
    state_t          state;
    op_t             op;
    logic [11:0]     opr, x, y, res, a_in, fin;
    logic [1:0]      dig;
    logic [3:0]      d, cur;
    logic [TW-1:0]   tick;
    logic [SW-1:0]   secs;
    logic            c, sub, sgn, ack_q, err_q, done_q, add_in, a_big, swap, co, launch, pulse;
    bcd_digit_alu u_alu (.a(x[3:0]), .b(y[3:0]), .ci(c), .sub(sub), .d(d), .co(co));
    // Operand order and result sign are decided once, from bal as it stands at CALC entry
    always_comb begin
        a_in = state == ENTRY ? entry : opr;
        add_in = (state != ENTRY) == bal_neg;
        a_big = state == ENTRY ? a_in >= bal : a_in > bal;
        swap = !add_in && a_big;
        fin = !sub && co ? BCD_MAX : {d, res[11:4]};
        cur = entry[{entry_pos, 2'b00} +: 4];
        pulse = sel_p | inc_p | ok_p;
        launch = (state == IDLE && ack_q && !err_q) || (state == ENTRY && ok_p);
    end
    assign chg.chg_ack = ack_q & on;
    assign chg.chg_err = err_q & on;
    assign chg.chg_done = done_q & on;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op <= OP_CHG;
            bal <= INIT_BAL;
            bal_neg <= 1'b0;
            entry <= 12'h0;
            entry_pos <= 2'd0;
            busy <= 1'b0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            done_q <= 1'b0;
            opr <= 12'h0;
            x <= 12'h0;
            y <= 12'h0;
            res <= 12'h0;
            dig <= 2'd0;
            c <= 1'b0;
            sub <= 1'b0;
            sgn <= 1'b0;
            tick <= '0;
            secs <= '0;
        end else if (on) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (chg.chg_req && !ack_q) begin
                        ack_q <= 1'b1;
                        err_q <= !bcd_ok(chg.chg_amt);
                        opr <= chg.chg_amt;
                    end else if (ok_p) begin
                        state <= ENTRY;
                        entry <= 12'h0;
                        entry_pos <= 2'd0;
                        tick <= '0;
                        secs <= '0;
                    end
                end
                ENTRY: begin
                    if (pulse) begin
                        tick <= '0;
                        secs <= '0;
                        if (sel_p) entry_pos <= entry_pos == 2'd2 ? 2'd0 : entry_pos + 2'd1;
                        if (inc_p) entry[{entry_pos, 2'b00} +: 4] <= cur == 4'd9 ? 4'd0 : cur + 4'd1;
                    end else if (tick == TW'(CLK_HZ - 1)) begin
                        tick <= '0;
                        secs <= secs + SW'(1);
                        if (secs == SW'(TIMEOUT_S - 1)) begin
                            state <= IDLE;
                            entry <= 12'h0;
                            entry_pos <= 2'd0;
                            secs <= '0;
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                CALC: begin
                    x <= {4'h0, x[11:4]};
                    y <= {4'h0, y[11:4]};
                    res <= {d, res[11:4]};
                    c <= co;
                    dig <= dig + 2'd1;
                    if (dig == 2'd2) begin
                        state <= WB;
                        bal <= fin;
                        bal_neg <= sgn && fin != 12'h0;
                        done_q <= op == OP_CHG;
                        entry <= 12'h0;
                        entry_pos <= 2'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
            if (launch) begin
                state <= CALC;
                busy <= 1'b1;
                op <= state == ENTRY ? OP_TOP : OP_CHG;
                x <= swap ? a_in : bal;
                y <= swap ? bal : a_in;
                sub <= !add_in;
                sgn <= add_in ? bal_neg : (state == ENTRY ? !a_big : a_big);
                c <= 1'b0;
                dig <= 2'd0;
            end
        end
    end
endmodule
